n64_vmode_detect: RTL and testbench

// Detects N64 video mode from the VI sync stream in the N64 pixel-clock domain.

---
 rtl/n64_vmode_detect.sv | 191 +++++++++++++++++++
 tb/tb_n64_vmode_detect.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/n64_vmode_detect.sv
// N64 VI video-mode detector: counts lines per field and the half-line phase of vsync
// to derive PAL/NTSC, interlaced/progressive and field parity, with field-count hysteresis.
module n64_vmode_detect #(
    parameter logic [9:0]  PAL_LINE_THRESH = 10'd288,
    parameter logic [9:0]  LINE_MIN        = 10'd200,
    parameter logic [9:0]  LINE_MAX        = 10'd400,
    parameter int unsigned HYST_FIELDS     = 2
) (
    input  logic       N64_CLK_i,
    input  logic       nRST_i,
    input  logic       vdata_valid_i,
    input  logic       nVSYNC_i,
    input  logic       nHSYNC_i,
    output logic       palmode_o,
    output logic       interlaced_o,
    output logic       field_o,
    output logic       vmode_valid_o,
    output logic       new_field_o,
    output logic [9:0] lines_o
);

    typedef enum logic [1:0] {StInit, StMeas, StLock} state_e;

    localparam logic [7:0] HystLast = 8'(HYST_FIELDS - 1);

    state_e      state_q, state_d;
    logic        nv_q, nv_d, nh_q, nh_d;
    logic [11:0] h_pos_q, h_pos_d, h_len_q, h_len_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic [7:0]  hyst_q, hyst_d;
    logic        prev_half_q, prev_half_d, prev_half_vld_q, prev_half_vld_d;
    logic [1:0]  prev_cand_q, prev_cand_d;
    logic        prev_cand_vld_q, prev_cand_vld_d;
    logic        pal_q, pal_d, int_q, int_d, field_q, field_d;
    logic        valid_q, valid_d, new_field_q, new_field_d;
    logic [9:0]  lines_q, lines_d;

    logic        h_edge, v_edge, half, fld_ok;
    logic [9:0]  line_eff;
    logic [11:0] h_len_eff;
    logic [1:0]  cand;

    assign h_edge = vdata_valid_i & ~nHSYNC_i & nh_q;
    assign v_edge = vdata_valid_i & ~nVSYNC_i & nv_q;

    always_comb begin
        state_d         = state_q;
        nv_d            = nv_q;
        nh_d            = nh_q;
        h_pos_d         = h_pos_q;
        h_len_d         = h_len_q;
        line_cnt_d      = line_cnt_q;
        hyst_d          = hyst_q;
        prev_half_d     = prev_half_q;
        prev_half_vld_d = prev_half_vld_q;
        prev_cand_d     = prev_cand_q;
        prev_cand_vld_d = prev_cand_vld_q;
        pal_d           = pal_q;
        int_d           = int_q;
        field_d         = field_q;
        valid_d         = valid_q;
        new_field_d     = 1'b0;
        lines_d         = lines_q;
        line_eff        = line_cnt_q;
        h_len_eff       = h_len_q;

        if (vdata_valid_i) begin
            nv_d = nVSYNC_i;
            nh_d = nHSYNC_i;
            if (h_edge) begin
                h_pos_d    = 12'd0;
                h_len_d    = h_pos_q;
                h_len_eff  = h_pos_q;
                line_eff   = (line_cnt_q == 10'h3ff) ? line_cnt_q : line_cnt_q + 10'd1;
                line_cnt_d = line_eff;
            end else if (h_pos_q != 12'hfff) begin
                h_pos_d = h_pos_q + 12'd1;
            end
        end

        // A coincident hsync restarts the line, so the vsync lands at h_pos 0.
        half   = ~h_edge & (h_len_q != 12'd0) & (h_pos_q >= (h_len_q >> 1));
        fld_ok = (line_eff >= LINE_MIN) & (line_eff <= LINE_MAX) & (h_len_eff != 12'd0);
        cand   = {line_eff >= PAL_LINE_THRESH, prev_half_vld_q & (half != prev_half_q)};

        if (v_edge) begin
            line_cnt_d  = 10'd0;
            lines_d     = line_eff;
            new_field_d = 1'b1;
            field_d     = half;
            if (!fld_ok) begin
                valid_d         = 1'b0;
                hyst_d          = 8'd0;
                prev_half_vld_d = 1'b0;
                prev_cand_vld_d = 1'b0;
                state_d         = StMeas;
            end else begin
                case (state_q)
                    StInit: begin
                        hyst_d  = 8'd0;
                        state_d = StMeas;
                    end
                    StMeas: begin
                        prev_half_d     = half;
                        prev_half_vld_d = 1'b1;
                        prev_cand_d     = cand;
                        prev_cand_vld_d = 1'b1;
                        if (hyst_q == HystLast) begin
                            {pal_d, int_d} = cand;
                            valid_d        = 1'b1;
                            hyst_d         = 8'd0;
                            state_d        = StLock;
                        end else if (!prev_cand_vld_q || cand == prev_cand_q) begin
                            hyst_d = hyst_q + 8'd1;
                        end else begin
                            hyst_d = 8'd0;
                        end
                    end
                    StLock: begin
                        prev_half_d     = half;
                        prev_half_vld_d = 1'b1;
                        prev_cand_d     = cand;
                        prev_cand_vld_d = 1'b1;
                        if (cand == {pal_q, int_q}) begin
                            hyst_d = 8'd0;
                        end else if (hyst_q == 8'd0 || cand == prev_cand_q) begin
                            if (hyst_q == HystLast) begin
                                {pal_d, int_d} = cand;
                                hyst_d         = 8'd0;
                            end else begin
                                hyst_d = hyst_q + 8'd1;
                            end
                        end else begin
                            // New differing candidate restarts the streak at one field.
                            hyst_d = 8'd1;
                        end
                    end
                    default: state_d = StInit;
                endcase
            end
        end
    end

    always_ff @(posedge N64_CLK_i) begin
        if (!nRST_i) begin
            state_q         <= StInit;
            nv_q            <= 1'b1;
            nh_q            <= 1'b1;
            h_pos_q         <= 12'd0;
            h_len_q         <= 12'd0;
            line_cnt_q      <= 10'd0;
            hyst_q          <= 8'd0;
            prev_half_q     <= 1'b0;
            prev_half_vld_q <= 1'b0;
            prev_cand_q     <= 2'd0;
            prev_cand_vld_q <= 1'b0;
            pal_q           <= 1'b0;
            int_q           <= 1'b0;
            field_q         <= 1'b0;
            valid_q         <= 1'b0;
            new_field_q     <= 1'b0;
            lines_q         <= 10'd0;
        end else begin
            state_q         <= state_d;
            nv_q            <= nv_d;
            nh_q            <= nh_d;
            h_pos_q         <= h_pos_d;
            h_len_q         <= h_len_d;
            line_cnt_q      <= line_cnt_d;
            hyst_q          <= hyst_d;
            prev_half_q     <= prev_half_d;
            prev_half_vld_q <= prev_half_vld_d;
            prev_cand_q     <= prev_cand_d;
            prev_cand_vld_q <= prev_cand_vld_d;
            pal_q           <= pal_d;
            int_q           <= int_d;
            field_q         <= field_d;
            valid_q         <= valid_d;
            new_field_q     <= new_field_d;
            lines_q         <= lines_d;
        end
    end

    assign palmode_o     = pal_q;
    assign interlaced_o  = int_q;
    assign field_o       = field_q;
    assign vmode_valid_o = valid_q;
    assign new_field_o   = new_field_q;
    assign lines_o       = lines_q;

endmodule

// File: tb/tb_n64_vmode_detect.sv
// Randomized field generator with a field-level reference model and a scoreboard
// checked on every new_field_o pulse.
module tb_n64_vmode_detect;

    localparam int L = 10;  // dv samples per line; hsync low for the first 3

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0, nv = 1'b1, nh = 1'b1;
    logic       palmode, interlaced, field, vvalid, new_field;
    logic [9:0] lines;

    n64_vmode_detect dut (
        .N64_CLK_i    (clk),
        .nRST_i       (rst_n),
        .vdata_valid_i(dv),
        .nVSYNC_i     (nv),
        .nHSYNC_i     (nh),
        .palmode_o    (palmode),
        .interlaced_o (interlaced),
        .field_o      (field),
        .vmode_valid_o(vvalid),
        .new_field_o  (new_field),
        .lines_o      (lines)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] lines;
        logic       field;
        logic       pal;
        logic       intl;
        logic       valid;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Field-level reference model state.
    int       lines_since, h_len_m, streak;
    bit       first_line, discard, locked, have_ref, prev_half, prev_half_ok, valid_m;
    bit [1:0] ref_c, out_c;

    task automatic model_reset();
        lines_since = 0; h_len_m = 0; streak = 0;
        first_line = 1; discard = 1; locked = 0; have_ref = 0;
        prev_half = 0; prev_half_ok = 0; valid_m = 0;
        ref_c = 0; out_c = 0;
    endtask

    task automatic model_close(input int vpos);
        int       nl;
        bit       half, ok;
        bit [1:0] cand;
        exp_t     e;
        nl   = lines_since;
        half = (vpos != 0) && (h_len_m != 0) && ((vpos - 1) >= h_len_m / 2);
        ok   = (nl >= 200) && (nl <= 400) && (h_len_m != 0);
        lines_since = 0;
        if (!ok) begin
            valid_m = 0; locked = 0; have_ref = 0; streak = 0; prev_half_ok = 0; discard = 0;
        end else if (discard) begin
            discard = 0; streak = 0;
        end else begin
            cand = {nl >= 288, prev_half_ok && (half != prev_half)};
            prev_half = half; prev_half_ok = 1;
            if (!locked) begin
                if (streak + 1 == 2) begin
                    out_c = cand; valid_m = 1; locked = 1; streak = 0;
                end else if (!have_ref || cand == ref_c) streak++;
                else streak = 0;
            end else if (cand == out_c) begin
                streak = 0;
            end else if (streak == 0 || cand == ref_c) begin
                streak++;
                if (streak == 2) begin out_c = cand; streak = 0; end
            end else begin
                streak = 1;
            end
            ref_c = cand; have_ref = 1;
        end
        e.lines = 10'(nl); e.field = half; e.pal = out_c[1]; e.intl = out_c[0]; e.valid = valid_m;
        sb_q.push_back(e);
    endtask

    task automatic cycle(input logic d, input logic v, input logic h);
        dv = d; nv = v; nh = h;
        @(posedge clk);
        #1;
    endtask

    // Random dv gaps carry garbage sync levels that must be ignored.
    task automatic sample(input logic v, input logic h);
        while ($urandom_range(15) == 0)
            cycle(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
        cycle(1'b1, v, h);
    endtask

    task automatic line(input int vpos);
        h_len_m = first_line ? 0 : L - 1;
        first_line = 0;
        if (lines_since < 1023) lines_since++;
        for (int i = 0; i < L; i++) begin
            if (i == vpos) model_close(vpos);
            sample(!(vpos >= 0 && i >= vpos && i < vpos + 4), i >= 3);
        end
    endtask

    task automatic send_field(input int n, input int vpos);
        line(vpos);
        for (int k = 1; k < n; k++) line(-1);
    endtask

    function automatic int lowp();
        return int'($urandom_range(1, 4));
    endfunction

    function automatic int highp();
        return int'($urandom_range(5, 6));
    endfunction

    task automatic check_zero(input string name);
        vectors++;
        if ({palmode, interlaced, field, vvalid, new_field, lines} !== 15'd0) begin
            miscompares++;
            $display("FAIL %s: outputs pal=%b int=%b fld=%b vld=%b nf=%b lines=%0d, required all 0",
                     name, palmode, interlaced, field, vvalid, new_field, lines);
        end
    endtask

    // Monitor: every field-close pulse is checked against the oldest expectation.
    initial begin
        exp_t e, g;
        forever begin
            @(negedge clk);
            if (rst_n && new_field) begin
                vectors++;
                g = {lines, field, palmode, interlaced, vvalid};
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_field: got lines=%0d, required no field close", lines);
                end else begin
                    e = sb_q.pop_front();
                    if (g !== e) begin
                        miscompares++;
                        $display("FAIL field_close: got lines=%0d fld=%b pal=%b int=%b vld=%b, required lines=%0d fld=%b pal=%b int=%b vld=%b",
                                 g.lines, g.field, g.pal, g.intl, g.valid,
                                 e.lines, e.field, e.pal, e.intl, e.valid);
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        check_zero("reset_state");
        rst_n = 1'b1;

        // NTSC 240p: first close discarded, locks on third.
        send_field(262, lowp());
        send_field(262, lowp());
        send_field(262, lowp());
        // Switch to PAL progressive: takes effect on second PAL close.
        send_field(312, lowp());
        send_field(312, lowp());
        send_field(312, lowp());
        // PAL 576i: vsync alternates between line start and mid-line.
        send_field(313, highp());
        send_field(312, lowp());
        send_field(313, highp());
        // Short field drops validity; two good fields restore it.
        send_field(150, lowp());
        send_field(262, lowp());
        send_field(262, lowp());
        // Coincident hsync/vsync edge.
        send_field(262, 0);
        // Mid-field reset with dv toggling.
        line(lowp());
        for (int k = 0; k < 99; k++) line(-1);
        cycle(1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        check_zero("mid_field_reset");
        rst_n = 1'b1;
        model_reset();
        send_field(262, lowp());
        send_field(262, lowp());
        // Loss of vsync: line counter saturates and the next close is invalid.
        send_field(1100, lowp());
        line(lowp());

        repeat (5) cycle(1'b0, 1'b1, 1'b1);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_fields: %0d expected field closes never seen, required 0",
                     sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
